dsp_chain_drain: RTL and testbench
==================================

DSP_CHAIN_DRAIN -- requirements
Module: dsp_chain_drain

Interface
REQ-001 SHALL have parameter ACC_LEN, default 8, chain beats summed per result (>=1).
REQ-002 SHALL have parameter OUT_W, default 32, signed result width (<=37).
REQ-003 SHALL have parameter SHIFT, default 0, arithmetic right shift applied before saturation.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of 2).
REQ-005 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port chain_valid  in  1  chain_data carries a beat this cycle.
REQ-008 SHALL have port chain_data  in  37  signed chainout of the last int_sop_2 stage.
REQ-009 SHALL have port flush  in  1  emit the partial group now.
REQ-010 SHALL have port out_ready  in  1  consumer accepts out_data.
REQ-011 SHALL have port out_valid  out  1  FIFO head valid.
REQ-012 SHALL have port out_data  out  OUT_W  signed result at FIFO head.
REQ-013 SHALL have port out_sat  out  1  head result was saturated.
REQ-014 SHALL have port stall  out  1  upstream must hold chain_valid low.
REQ-015 SHALL have port drop_err  out  1  sticky: a beat arrived while stall=1.

Function
REQ-016 SHALL run FSM ACCUM/EMIT; reset state ACCUM, beat count 0, accumulator 0.
REQ-017 SHALL, in ACCUM, on chain_valid add sign-extended chain_data to accumulator (width 37+clog2(ACC_LEN)+1) and increment count.
REQ-018 SHALL, on the ACC_LEN-th beat, latch the sum including that beat into the result register and enter EMIT next cycle.
REQ-019 SHALL, on flush with count>0 (or with a concurrent beat), latch the sum including any concurrent beat and enter EMIT; flush with count=0 and no beat SHALL be ignored.
REQ-020 SHALL compute result = sum >>> SHIFT (floor), then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 iff clamped.
REQ-021 SHALL, in EMIT with FIFO not full, write {result,sat} to FIFO, clear count/accumulator, return to ACCUM in that cycle.
REQ-022 SHALL accept a chain_valid beat in a writing EMIT cycle as beat 1 of the next group (zero-bubble streaming).
REQ-023 SHALL, in EMIT with FIFO full, remain in EMIT holding the result until space frees.
REQ-024 SHALL drive stall = (state==EMIT and FIFO full) combinationally.
REQ-025 SHALL discard any beat with chain_valid=1 while stall=1 and set drop_err until reset.
REQ-026 SHALL pop FIFO on out_valid&out_ready; simultaneous push and pop on a full FIFO SHALL both succeed and stall SHALL be 0.
REQ-027 SHALL give latency: last beat at cycle N -> out_valid at N+2 when FIFO empty.
REQ-028 SHALL hold out_data/out_sat stable while out_valid=1 and out_ready=0.

Reset
REQ-029 SHALL on reset clear FSM to ACCUM, count, accumulator, result register, FIFO pointers, drop_err; out_valid=0, out_data=0, out_sat=0, stall=0.
REQ-030 SHALL discard any partial group and queued results on reset mid-operation; first beat after release starts a new group.

Structure
REQ-031 SHALL place CHAIN_W=37 and the FSM state enum in shared package dsp_chain_pkg.
REQ-032 SHALL implement the result FIFO as sub-module dsp_result_fifo (width OUT_W+1, depth FIFO_DEPTH, full/empty flags, async active-high reset).

Verification (ACC_LEN=4, OUT_W=32, FIFO_DEPTH=4, SHIFT=0 unless noted)
REQ-033 SHALL check: beats 1,2,3,4 back-to-back, out_ready=1 -> out_data=10, out_sat=0, out_valid 2 cycles after beat 4.
REQ-034 SHALL check: four beats of 2^35 -> out_data=0x7FFFFFFF, out_sat=1; four beats of -2^35 -> 0x80000000, out_sat=1.
REQ-035 SHALL check: SHIFT=1, four beats of -5 -> out_data=-10; beats -1,0,0,0 -> out_data=-1.
REQ-036 SHALL check: out_ready=0, 20 streamed beats -> 4 results queued, stall=1, 5th held, further beats dropped, drop_err=1; out_ready=1 -> results drain in order, stall falls.
REQ-037 SHALL check: beats 7,8 then flush -> out_data=15; flush with no pending beats -> no output.
REQ-038 SHALL check: reset asserted after 2 beats of a group -> no output; then 1,1,1,1 -> out_data=4.

Source files
------------

// File: rtl/dsp_chain_pkg.sv
// -----------------------------------------------------------------------------
// dsp_chain_pkg
// Shared definitions for the chainout drain block: chain beat width, FSM state
// type and the accumulator width helper.
// -----------------------------------------------------------------------------
package dsp_chain_pkg;

  localparam int CHAIN_W = 37;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_e;

  // Wide enough to sum acc_len full-scale beats without overflow, plus one
  // guard bit so the sign survives the worst-case negative group.
  function automatic int acc_width(input int acc_len);
    return CHAIN_W + $clog2(acc_len) + 1;
  endfunction

endpackage

// File: rtl/dsp_result_fifo.sv
// -----------------------------------------------------------------------------
// dsp_result_fifo
// Small synchronous FIFO holding {sat, result} words.
// Ports:
//   clk, reset        clock, async active-high reset (pointers only)
//   push, wdata       write request / data (ignored when full unless popping)
//   pop               read request (ignored when empty)
//   rdata             head word, zero when empty
//   full, empty       occupancy flags
// DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module dsp_result_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // A pop frees the head slot in the same cycle, so push on full is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dsp_chain_drain.sv
// -----------------------------------------------------------------------------
// dsp_chain_drain
// Sums groups of ACC_LEN chainout beats from the last int_sop_2 stage, scales
// (arithmetic shift) and saturates each sum, and queues results in a FIFO.
// Ports:
//   clk, reset              clock, async active-high reset
//   chain_valid, chain_data signed 37-bit chain beat
//   flush                   close the current partial group now
//   out_ready               consumer accepts head result
//   out_valid, out_data     FIFO head result (signed OUT_W)
//   out_sat                 head result was clamped
//   stall                   upstream must not present beats
//   drop_err                sticky: a beat arrived while stalled
//
// state    | meaning
// ST_ACCUM | summing beats into the accumulator
// ST_EMIT  | result latched, waiting for FIFO space to write it
// -----------------------------------------------------------------------------
module dsp_chain_drain
  import dsp_chain_pkg::*;
#(
  parameter int ACC_LEN    = 8,
  parameter int OUT_W      = 32,
  parameter int SHIFT      = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      chain_valid,
  input  logic signed [CHAIN_W-1:0] chain_data,
  input  logic                      flush,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_sat,
  output logic                      stall,
  output logic                      drop_err
);

  localparam int AW = acc_width(ACC_LEN);
  localparam int CW = $clog2(ACC_LEN + 1);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_e               state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OUT_W:0]       res_q, res_d;
  logic                 drop_q, drop_d;

  logic                 f_full, f_empty, push, pop, accept, step;
  logic [OUT_W:0]       f_rdata;
  logic signed [AW-1:0] sum_in, shifted;
  logic [CW-1:0]        cnt_in;
  logic [OUT_W-1:0]     sat_val;
  logic                 sat_flag;

  assign out_valid = !f_empty;
  assign pop       = out_valid && out_ready;
  assign push      = (state_q == ST_EMIT) && (!f_full || pop);
  assign stall     = (state_q == ST_EMIT) && f_full && !pop;
  assign accept    = chain_valid && !stall;
  // Accumulate in ACCUM, and also in the EMIT cycle that writes, so a beat
  // there becomes beat 1 of the next group without a bubble.
  assign step      = (state_q == ST_ACCUM) || push;

  // acc_q/cnt_q are zeroed on entry to EMIT, so the same sum path serves both.
  assign sum_in = acc_q + (accept ? {{(AW-CHAIN_W){chain_data[CHAIN_W-1]}}, chain_data}
                                  : {AW{1'b0}});
  assign cnt_in = cnt_q + CW'(accept);

  always_comb begin
    shifted  = sum_in >>> SHIFT;
    sat_flag = 1'b0;
    sat_val  = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX) begin
      sat_flag = 1'b1;
      sat_val  = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_flag = 1'b1;
      sat_val  = SAT_MIN[OUT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    drop_d  = drop_q | (chain_valid & stall);
    if (push) state_d = ST_ACCUM;
    if (step) begin
      acc_d = sum_in;
      cnt_d = cnt_in;
      if ((cnt_in == CW'(ACC_LEN)) || (flush && (cnt_in != '0))) begin
        res_d   = {sat_flag, sat_val};
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_EMIT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      drop_q  <= drop_d;
    end
  end

  dsp_result_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (res_q),
    .pop   (pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  assign out_data = f_rdata[OUT_W-1:0];
  assign out_sat  = f_rdata[OUT_W];
  assign drop_err = drop_q;

endmodule

// File: tb/tb_dsp_chain_drain.sv
// -----------------------------------------------------------------------------
// tb_dsp_chain_drain
// Two instances (SHIFT=0 and SHIFT=1) share one directed stimulus stream and
// are checked every cycle against a group-sum / result-queue model, plus
// literal expectations on the popped result sequences.
// -----------------------------------------------------------------------------
module tb_dsp_chain_drain;

  localparam int ACC_LEN = 4;
  localparam int OUT_W   = 32;
  localparam int DEPTH   = 4;
  localparam int NEXP    = 13;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chain_valid = 1'b0;
  logic [36:0] chain_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;

  logic [1:0]  ov, osat, ostall, odrop;
  logic [31:0] od [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dsp_chain_drain #(.ACC_LEN(ACC_LEN), .OUT_W(OUT_W), .SHIFT(0), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .reset(reset), .chain_valid(chain_valid), .chain_data(chain_data),
    .flush(flush), .out_ready(out_ready), .out_valid(ov[0]), .out_data(od[0]),
    .out_sat(osat[0]), .stall(ostall[0]), .drop_err(odrop[0]));

  dsp_chain_drain #(.ACC_LEN(ACC_LEN), .OUT_W(OUT_W), .SHIFT(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .reset(reset), .chain_valid(chain_valid), .chain_data(chain_data),
    .flush(flush), .out_ready(out_ready), .out_valid(ov[1]), .out_data(od[1]),
    .out_sat(osat[1]), .stall(ostall[1]), .drop_err(odrop[1]));

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h, want %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index k doubles as SHIFT) ----------------
  longint     gsum [2];
  int         gcnt [2];
  logic       pend_v [2];
  logic [32:0] pend [2];
  logic [32:0] mq [2][DEPTH];
  int         mhead [2];
  int         mocc [2];
  logic       mdrop [2];

  function automatic logic [32:0] expect_result(input longint s, input int sh);
    longint r;
    r = s >>> sh;
    if (r > 64'sd2147483647)       return {1'b1, 32'h7FFF_FFFF};
    else if (r < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    else                           return {1'b0, r[31:0]};
  endfunction

  function automatic logic model_stall(input int k);
    return pend_v[k] && (mocc[k] == DEPTH) && !((mocc[k] > 0) && out_ready);
  endfunction

  task automatic model_step(input int k);
    logic   popm, stl;
    longint dv;
    popm = (mocc[k] > 0) && out_ready;
    stl  = model_stall(k);
    if (chain_valid && stl) mdrop[k] = 1'b1;
    if (popm) begin
      mhead[k] = (mhead[k] + 1) % DEPTH;
      mocc[k]--;
    end
    if (pend_v[k] && !stl) begin
      mq[k][(mhead[k] + mocc[k]) % DEPTH] = pend[k];
      mocc[k]++;
      pend_v[k] = 1'b0;
    end
    if (!pend_v[k]) begin
      if (chain_valid) begin
        dv = longint'($signed(chain_data));
        gsum[k] += dv;
        gcnt[k]++;
      end
      if (gcnt[k] == ACC_LEN || (flush && gcnt[k] > 0)) begin
        pend[k]   = expect_result(gsum[k], k);
        pend_v[k] = 1'b1;
        gsum[k]   = 0;
        gcnt[k]   = 0;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        gsum[k] = 0; gcnt[k] = 0; pend_v[k] = 1'b0; pend[k] = '0;
        mhead[k] = 0; mocc[k] = 0; mdrop[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  // ---------------- per-cycle compare and pop log ----------------
  logic [32:0] plog [2][32];
  int          plog_n [2];
  initial begin
    plog_n[0] = 0;
    plog_n[1] = 0;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("out_valid", k, longint'(ov[k]), longint'(mocc[k] > 0));
      chk("stall", k, longint'(ostall[k]), longint'(model_stall(k)));
      chk("drop_err", k, longint'(odrop[k]), longint'(mdrop[k]));
      if (mocc[k] > 0) begin
        chk("out_data", k, longint'(od[k]), longint'(mq[k][mhead[k]][31:0]));
        chk("out_sat", k, longint'(osat[k]), longint'(mq[k][mhead[k]][32]));
      end
      if (ov[k] && out_ready && plog_n[k] < 32) begin
        plog[k][plog_n[k]] = {osat[k], od[k]};
        plog_n[k]++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic v, input longint d, input logic f);
    chain_valid = v;
    chain_data  = d[36:0];
    flush       = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0);
  endtask

  logic [32:0] exp0 [NEXP] = '{33'h0_0000000A, 33'h1_7FFFFFFF, 33'h1_80000000, 33'h0_FFFFFFEC,
                               33'h0_FFFFFFFF, 33'h0_0000000F, 33'h0_00000005, 33'h0_00000004,
                               33'h0_0000000A, 33'h0_0000001A, 33'h0_0000002A, 33'h0_0000003A,
                               33'h0_0000004A};
  logic [32:0] exp1 [NEXP] = '{33'h0_00000005, 33'h1_7FFFFFFF, 33'h1_80000000, 33'h0_FFFFFFF6,
                               33'h0_FFFFFFFF, 33'h0_00000007, 33'h0_00000002, 33'h0_00000002,
                               33'h0_00000005, 33'h0_0000000D, 33'h0_00000015, 33'h0_0000001D,
                               33'h0_00000025};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 0, longint'(ov[0]), 0);
    chk("rst_data", 0, longint'(od[0]), 0);
    chk("rst_sat", 0, longint'(osat[0]), 0);
    chk("rst_stall", 0, longint'(ostall[0]), 0);
    reset = 1'b0;
    idle(1);

    // 1+2+3+4, latency: EMIT cycle shows nothing, next cycle shows 10
    cyc(1'b1, 1, 1'b0); cyc(1'b1, 2, 1'b0); cyc(1'b1, 3, 1'b0); cyc(1'b1, 4, 1'b0);
    chk("lat_n1_valid", 0, longint'(ov[0]), 0);
    idle(1);
    chk("lat_n2_valid", 0, longint'(ov[0]), 1);
    chk("lat_n2_data", 0, longint'(od[0]), 10);
    idle(2);

    // saturation both ways
    for (int i = 0; i < 4; i++) cyc(1'b1, 64'sd34359738368, 1'b0);
    idle(2);
    for (int i = 0; i < 4; i++) cyc(1'b1, -64'sd34359738368, 1'b0);
    idle(2);

    // negative sums and floor behaviour of the shift
    for (int i = 0; i < 4; i++) cyc(1'b1, -5, 1'b0);
    cyc(1'b1, -1, 1'b0); cyc(1'b1, 0, 1'b0); cyc(1'b1, 0, 1'b0); cyc(1'b1, 0, 1'b0);
    idle(3);

    // flush of a partial group, empty flush, flush with concurrent first beat
    cyc(1'b1, 7, 1'b0); cyc(1'b1, 8, 1'b0); cyc(1'b0, 0, 1'b1);
    idle(4);
    cyc(1'b0, 0, 1'b1);
    idle(4);
    cyc(1'b1, 5, 1'b1);
    idle(4);

    // reset in the middle of a group discards it
    cyc(1'b1, 9, 1'b0); cyc(1'b1, 9, 1'b0);
    chain_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", 0, longint'(ov[0]), 0);
    reset = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1, 1'b0);
    idle(4);

    // back-pressure: fill FIFO, hold 5th result, drop further beats
    out_ready = 1'b0;
    for (int i = 1; i <= 22; i++) cyc(1'b1, longint'(i), 1'b0);
    idle(1);
    chk("bp_stall", 0, longint'(ostall[0]), 1);
    chk("bp_drop", 0, longint'(odrop[0]), 1);
    chk("bp_head", 0, longint'(od[0]), 10);
    out_ready = 1'b1;
    idle(10);
    chk("bp_stall_fall", 0, longint'(ostall[0]), 0);

    for (int k = 0; k < 2; k++) begin
      chk("pop_count", k, longint'(plog_n[k]), NEXP);
      for (int i = 0; i < NEXP && i < plog_n[k]; i++)
        chk($sformatf("pop_seq%0d", i), k, longint'(plog[k][i]),
            longint'(k == 0 ? exp0[i] : exp1[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
